// File: rtl/rr_trace_packer.sv
// Trace record packer: LSB-aligned variable-width packets in, dense AXI_WIDTH beats out, with flush/burst padding.
// Optional statistics counters (pkt_cnt, bit_cnt) are built when RR_PACKER_STATS_EN is defined.
module rr_trace_packer #(
  parameter int WIDTH        = 1161,
  parameter int AXI_WIDTH    = 512,
  parameter int OFFSET_WIDTH = $clog2(WIDTH-1)+1,
  parameter int BURST_BEATS  = 1,
  parameter int CNT_WIDTH    = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  input  logic [OFFSET_WIDTH-1:0] in_width,
  input  logic                    finish,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [AXI_WIDTH-1:0]    out_data,
  output logic                    out_last,
  output logic                    flush_done,
  output logic                    err_width,
  output logic [CNT_WIDTH-1:0]    beat_cnt
`ifdef RR_PACKER_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]    pkt_cnt,
  output logic [CNT_WIDTH-1:0]    bit_cnt
`endif
);

  localparam int BUF_W  = AXI_WIDTH + WIDTH - 1;
  localparam int FILL_W = $clog2(BUF_W + 1);
  localparam logic [FILL_W-1:0]       AXI_V      = FILL_W'(AXI_WIDTH);
  localparam logic [OFFSET_WIDTH-1:0] WIDTH_V    = OFFSET_WIDTH'(WIDTH);
  localparam logic [CNT_WIDTH-1:0]    BURST_MASK = CNT_WIDTH'(BURST_BEATS - 1);

  typedef enum logic [1:0] {RUN, FLUSH, PAD, DONE} state_t;

  state_t             state;
  logic [BUF_W-1:0]   pack_buf;
  logic [FILL_W-1:0]  fill;

  logic               out_fire;
  logic               in_fire;
  logic               width_ok;
  logic [FILL_W-1:0]  fill_out;
  logic [CNT_WIDTH-1:0] beat_inc;
  logic [BUF_W-1:0]   shifted;
  logic [BUF_W-1:0]   appended;

  function automatic logic [WIDTH-1:0] mask_width(input logic [WIDTH-1:0] d,
                                                  input logic [OFFSET_WIDTH-1:0] w);
    logic [WIDTH-1:0] m;
    m = '1;
    if (w < WIDTH_V) m = ~({WIDTH{1'b1}} << w);
    return d & m;
  endfunction

  function automatic logic aligned(input logic [CNT_WIDTH-1:0] c);
    return (c & BURST_MASK) == '0;
  endfunction

  assign out_fire = out_valid & out_ready;
  assign in_fire  = in_valid & in_ready;
  assign width_ok = in_width <= WIDTH_V;
  assign beat_inc = beat_cnt + CNT_WIDTH'(1);

  // A partial flush beat drains everything that is left, so fill never goes negative.
  assign fill_out = out_fire ? ((fill >= AXI_V) ? fill - AXI_V : '0) : fill;

  assign in_ready   = !rst && (state == RUN) && (fill_out < AXI_V);
  assign flush_done = (state == DONE);

  assign shifted  = out_fire ? (pack_buf >> AXI_WIDTH) : pack_buf;
  assign appended = BUF_W'(mask_width(in_data, in_width)) << fill_out;

  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = pack_buf[AXI_WIDTH-1:0];
    case (state)
      RUN:   out_valid = (fill >= AXI_V);
      FLUSH: begin
        out_valid = (fill != '0);
        out_last  = (fill != '0) && (fill <= AXI_V) && aligned(beat_inc);
      end
      PAD: begin
        out_valid = 1'b1;
        out_data  = '0;
        out_last  = aligned(beat_inc);
      end
      default: ;
    endcase
  end

  // Buffer, fill level and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pack_buf  <= '0;
      fill      <= '0;
      err_width <= 1'b0;
      beat_cnt  <= '0;
`ifdef RR_PACKER_STATS_EN
      pkt_cnt   <= '0;
      bit_cnt   <= '0;
`endif
    end else begin
      if (in_fire && width_ok) begin
        pack_buf <= shifted | appended;
        fill     <= fill_out + FILL_W'(in_width);
      end else begin
        pack_buf <= shifted;
        fill     <= fill_out;
      end
      if (in_fire && !width_ok) err_width <= 1'b1;
      if (out_fire) beat_cnt <= beat_inc;
`ifdef RR_PACKER_STATS_EN
      if (in_fire && width_ok) begin
        pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
        bit_cnt <= bit_cnt + CNT_WIDTH'(in_width);
      end
`endif
    end
  end

  // Flush sequencing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      case (state)
        RUN: if (finish) state <= FLUSH;
        FLUSH: begin
          if (fill == '0)
            state <= aligned(beat_cnt) ? DONE : PAD;
          else if (out_fire && (fill <= AXI_V))
            state <= aligned(beat_inc) ? DONE : PAD;
        end
        PAD:  if (out_fire && aligned(beat_inc)) state <= DONE;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_trace_packer.sv
// Directed bench for rr_trace_packer: reset, back-to-back packing, flush/padding, back-pressure, bad width.
module tb_rr_trace_packer;
  localparam int W  = 1161;
  localparam int AW = 512;
  localparam int OW = 12;
  localparam int CW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic in_valid, in_ready, finish, out_valid, out_ready, out_last, flush_done, err_width;
  logic [W-1:0]  in_data;
  logic [OW-1:0] in_width;
  logic [AW-1:0] out_data;
  logic [CW-1:0] beat_cnt;

  logic b_in_valid, b_in_ready, b_finish, b_out_valid, b_out_ready, b_out_last, b_flush_done, b_err_width;
  logic [W-1:0]  b_in_data;
  logic [OW-1:0] b_in_width;
  logic [AW-1:0] b_out_data;
  logic [CW-1:0] b_beat_cnt;

`ifdef RR_PACKER_STATS_EN
  logic [CW-1:0] pkt_cnt, bit_cnt, b_pkt_cnt, b_bit_cnt;
`endif

  rr_trace_packer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_width(in_width), .finish(finish), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .flush_done(flush_done), .err_width(err_width),
    .beat_cnt(beat_cnt)
`ifdef RR_PACKER_STATS_EN
    , .pkt_cnt(pkt_cnt), .bit_cnt(bit_cnt)
`endif
  );

  rr_trace_packer #(.BURST_BEATS(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_width(b_in_width), .finish(b_finish), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_last(b_out_last), .flush_done(b_flush_done), .err_width(b_err_width),
    .beat_cnt(b_beat_cnt)
`ifdef RR_PACKER_STATS_EN
    , .pkt_cnt(b_pkt_cnt), .bit_cnt(b_bit_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_cyc = -1;
  logic [AW-1:0] beat_q[$];
  bit            last_q[$];
  logic [AW-1:0] b_beat_q[$];
  bit            b_last_q[$];
  bit            ref_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Beats are recorded half a cycle before the edge on which they transfer.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        beat_q.push_back(out_data);
        last_q.push_back(out_last);
        if (out_last) last_cyc = cyc;
      end
      if (b_out_valid && b_out_ready) begin
        b_beat_q.push_back(b_out_data);
        b_last_q.push_back(b_out_last);
      end
    end
  end

  task automatic check(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_pkt();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < 37; i++) r = {r[W-33:0], 32'($urandom)};
    return r;
  endfunction

  task automatic send(input logic [W-1:0] d, input logic [OW-1:0] w, output int stalls);
    bit got;
    got = 1'b0;
    stalls = 0;
    in_valid = 1'b1; in_data = d; in_width = w;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_ready) begin got = 1'b1; break; end
      stalls++;
      @(posedge clk); #1;
    end
    check("send_accept", AW'(got), AW'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_finish();
    finish = 1'b1;
    @(posedge clk); #1;
    finish = 1'b0;
  endtask

  task automatic wait_done(output int at);
    bit ok;
    ok = 1'b0;
    at = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (flush_done) begin ok = 1'b1; at = cyc; break; end
    end
    check("flush_done_pulse", AW'(ok), AW'(1));
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; finish = 1'b0; out_ready = 1'b1;
    b_in_valid = 1'b0; b_finish = 1'b0; b_out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    beat_q.delete(); last_q.delete(); b_beat_q.delete(); b_last_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0]  p0, p1, p2;
    logic [AW-1:0] exp;
    int st, fd, nb;

    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_width = '0; finish = 1'b0; out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_width = '0; b_finish = 1'b0; b_out_ready = 1'b1;

    // Reset values
    @(negedge clk);
    check("rst_out_valid", AW'(out_valid), '0);
    check("rst_in_ready", AW'(in_ready), '0);
    check("rst_out_data", out_data, '0);
    check("rst_out_last", AW'(out_last), '0);
    check("rst_flush_done", AW'(flush_done), '0);
    check("rst_err_width", AW'(err_width), '0);
    check("rst_beat_cnt", AW'(beat_cnt), '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rel_in_ready", AW'(in_ready), AW'(1));
    check("rel_out_valid", AW'(out_valid), '0);
    @(posedge clk); #1;

    // Asynchronous reset with 300 bits buffered
    p0 = rand_pkt();
    send(p0, 12'd300, st);
    #2;
    check("pre_rst_fill", AW'(dut.fill), AW'(300));
    rst = 1'b1;
    #1;
    check("async_rst_out_data", out_data, '0);
    check("async_rst_in_ready", AW'(in_ready), '0);
    check("async_rst_fill", AW'(dut.fill), '0);
    @(posedge clk); #1;
    rst = 1'b0;
    beat_q.delete(); last_q.delete();
    @(negedge clk);
    check("post_rst_in_ready", AW'(in_ready), AW'(1));
    check("post_rst_out_valid", AW'(out_valid), '0);
    @(posedge clk); #1;

    // Three 300-bit packets back to back
    p0 = rand_pkt(); p1 = rand_pkt(); p2 = rand_pkt();
    send(p0, 12'd300, st);
    send(p1, 12'd300, st);
    send(p2, 12'd300, st);
    check("b2b_pkt2_no_stall", AW'(st), '0);
    check("b2b_fill", AW'(dut.fill), AW'(388));
    check("b2b_beats_so_far", AW'(beat_q.size()), AW'(1));
    check("b2b_beat0", beat_q[0], {p1[211:0], p0[299:0]});
    pulse_finish();
    wait_done(fd);
    check("b2b_beats_total", AW'(beat_q.size()), AW'(2));
    check("b2b_beat1", beat_q[1], {124'b0, p2[299:0], p1[299:212]});
    check("b2b_last0", AW'(last_q[0]), '0);
    check("b2b_last1", AW'(last_q[1]), AW'(1));
    check("b2b_beat_cnt", AW'(beat_cnt), AW'(2));

    // Maximum-width all-ones packet, then flush
    do_reset();
    send({W{1'b1}}, 12'd1161, st);
    pulse_finish();
    wait_done(fd);
    check("max_beats", AW'(beat_q.size()), AW'(3));
    check("max_beat0", beat_q[0], {AW{1'b1}});
    check("max_beat1", beat_q[1], {AW{1'b1}});
    check("max_beat2", beat_q[2], {375'b0, {137{1'b1}}});
    check("max_last01", AW'({last_q[0], last_q[1]}), '0);
    check("max_last2", AW'(last_q[2]), AW'(1));
    check("max_done_delay", AW'(fd - last_cyc), AW'(1));
    check("max_beat_cnt", AW'(beat_cnt), AW'(3));

    // Flush of an empty, aligned buffer
    finish = 1'b1;
    @(negedge clk);
    check("empty_fd_c0", AW'(flush_done), '0);
    @(posedge clk); #1;
    finish = 1'b0;
    @(negedge clk);
    check("empty_fd_c1", AW'(flush_done), '0);
    check("empty_no_valid", AW'(out_valid), '0);
    @(posedge clk); #1;
    @(negedge clk);
    check("empty_fd_c2", AW'(flush_done), AW'(1));
    check("empty_no_beat", AW'(beat_q.size()), AW'(3));
    check("empty_beat_cnt", AW'(beat_cnt), AW'(3));
    @(posedge clk); #1;

    // Back-pressure: 39-bit stream, out_ready low for 20 cycles
    do_reset();
    ref_q.delete();
    out_ready = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (k == 20) out_ready = 1'b1;
      p0 = rand_pkt();
      in_valid = 1'b1; in_data = p0; in_width = 12'd39;
      @(negedge clk);
      if (k == 13) check("bp_ready_507", AW'(in_ready), AW'(1));
      if (k == 14) check("bp_ready_546", AW'(in_ready), '0);
      if (k == 19) begin
        check("bp_stall_ready", AW'(in_ready), '0);
        check("bp_stall_valid", AW'(out_valid), AW'(1));
      end
      if (in_ready) for (int j = 0; j < 39; j++) ref_q.push_back(p0[j]);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    pulse_finish();
    wait_done(fd);
    nb = beat_q.size();
    check("bp_beats", AW'(nb), AW'(5));
    for (int b = 0; b < nb; b++) begin
      exp = '0;
      for (int j = 0; j < AW; j++) if (ref_q.size() > 0) exp[j] = ref_q.pop_front();
      check($sformatf("bp_beat%0d", b), beat_q[b], exp);
    end
    check("bp_ref_drained", AW'(ref_q.size()), '0);
    check("bp_last", AW'(last_q[nb-1]), AW'(1));

    // Burst padding to four beats
    do_reset();
    p0 = rand_pkt();
    b_in_valid = 1'b1; b_in_data = p0; b_in_width = 12'd39;
    @(negedge clk);
    check("burst_in_ready", AW'(b_in_ready), AW'(1));
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    b_finish = 1'b1;
    @(posedge clk); #1;
    b_finish = 1'b0;
    st = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (b_flush_done) begin st = 1; break; end
    end
    check("burst_flush_done", AW'(st), AW'(1));
    @(posedge clk); #1;
    check("burst_beats", AW'(b_beat_q.size()), AW'(4));
    check("burst_beat0", b_beat_q[0], {473'b0, p0[38:0]});
    check("burst_pad1", b_beat_q[1], '0);
    check("burst_pad2", b_beat_q[2], '0);
    check("burst_pad3", b_beat_q[3], '0);
    check("burst_last_early", AW'({b_last_q[0], b_last_q[1], b_last_q[2]}), '0);
    check("burst_last3", AW'(b_last_q[3]), AW'(1));
    check("burst_beat_cnt", AW'(b_beat_cnt), AW'(4));

    // Out-of-range width is swallowed and flagged
    do_reset();
    p1 = rand_pkt();
    send(p1, 12'd1200, st);
    check("bad_err_set", AW'(err_width), AW'(1));
    check("bad_fill", AW'(dut.fill), '0);
    p2 = rand_pkt();
    send(p2, 12'd39, st);
    check("bad_err_sticky", AW'(err_width), AW'(1));
`ifdef RR_PACKER_STATS_EN
    check("bad_pkt_cnt", AW'(pkt_cnt), AW'(1));
    check("bad_bit_cnt", AW'(bit_cnt), AW'(39));
`endif
    pulse_finish();
    wait_done(fd);
    check("bad_beats", AW'(beat_q.size()), AW'(1));
    check("bad_beat0", beat_q[0], {473'b0, p2[38:0]});
    check("bad_err_after_flush", AW'(err_width), AW'(1));
    do_reset();
    @(negedge clk);
    check("bad_err_cleared", AW'(err_width), '0);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
